// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite arbiter.
package axi4_lite_arb_pkg;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    // AXI response encodings, passed through to the requester unmodified.
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant logic, purely combinational.
// last = index of the requester granted most recently.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Lone requester wins; on contention the one not granted last wins.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path infers a latch.
        gnt = 2'b00;
        if (req[0] && (!req[1] || last)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Shares one AXI4-Lite master port between two command/done requesters.
// One transaction in flight; round-robin grants; full AW/W->B and AR->R sequencing.
module axi4_lite_req_arbiter
    import axi4_lite_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    // requester side
    input  logic [1:0]                      req_valid,
    input  logic [1:0]                      req_write,
    input  logic [2*ADDRESS_WIDTH-1:0]      req_addr,
    input  logic [2*DATA_WIDTH-1:0]         req_wdata,
    input  logic [2*(DATA_WIDTH/8)-1:0]     req_wstrb,
    output logic [1:0]                      req_ready,
    output logic [1:0]                      req_done,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    output logic [1:0]                      req_resp,
    // AXI4-Lite master: write address / data / response
    output logic                            awvalid,
    output logic [ADDRESS_WIDTH-1:0]        awaddr,
    input  logic                            awready,
    output logic                            wvalid,
    output logic [DATA_WIDTH-1:0]           wdata,
    output logic [DATA_WIDTH/8-1:0]         wstrb,
    input  logic                            wready,
    input  logic                            bvalid,
    input  logic [1:0]                      bresp,
    output logic                            bready,
    // AXI4-Lite master: read address / data
    output logic                            arvalid,
    output logic [ADDRESS_WIDTH-1:0]        araddr,
    input  logic                            arready,
    input  logic                            rvalid,
    input  logic [DATA_WIDTH-1:0]           rdata,
    input  logic [1:0]                      rresp,
    output logic                            rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_t                   state;
    state_t                   state_next;
    logic                     rr_last;     // index of the last granted requester
    logic                     grant_idx;   // requester owning the current transaction
    logic [1:0]               gnt;
    logic                     win_idx;
    logic                     sel_write;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic [STRB_WIDTH-1:0]    sel_wstrb;

    rr_arbiter_2 u_rr_arbiter (
        .req  (req_valid),
        .last (rr_last),
        .gnt  (gnt)
    );

    // Command fields of whichever requester the arbiter picks.
    assign win_idx   = gnt[1];
    assign sel_write = win_idx ? req_write[1] : req_write[0];
    assign sel_addr  = win_idx ? req_addr[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                               : req_addr[ADDRESS_WIDTH-1:0];
    assign sel_wdata = win_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                               : req_wdata[DATA_WIDTH-1:0];
    assign sel_wstrb = win_idx ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]
                               : req_wstrb[STRB_WIDTH-1:0];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, combinational acceptance and response-channel readies.
    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        bready     = 1'b0;
        rready     = 1'b0;
        case (state)
            IDLE: begin
                // Acceptance is suppressed while reset is held so no command is lost.
                if (!rst) begin
                    req_ready = gnt;
                end
                if (|gnt) begin
                    state_next = sel_write ? WR : RD_ADDR;
                end
            end
            WR: begin
                // AW and W may complete in either order; leave once both are done.
                if ((!awvalid || awready) && (!wvalid || wready)) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_next = IDLE;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command capture, AXI valid handshakes and response return to the requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last   <= 1'b1;
            grant_idx <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            arvalid   <= 1'b0;
            awaddr    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            araddr    <= '0;
            req_done  <= 2'b00;
            req_rdata <= '0;
            req_resp  <= OKAY;
        end else begin
            req_done <= 2'b00;

            if (|req_ready) begin
                grant_idx <= win_idx;
                rr_last   <= win_idx;
                if (sel_write) begin
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                    awaddr  <= sel_addr;
                    wdata   <= sel_wdata;
                    wstrb   <= sel_wstrb;
                end else begin
                    arvalid <= 1'b1;
                    araddr  <= sel_addr;
                end
            end

            // Each valid drops on its own handshake; payloads keep their last value.
            if (awvalid && awready) begin
                awvalid <= 1'b0;
            end
            if (wvalid && wready) begin
                wvalid <= 1'b0;
            end
            if (arvalid && arready) begin
                arvalid <= 1'b0;
            end

            if (bready && bvalid) begin
                req_resp <= bresp;
                req_done <= grant_idx ? 2'b10 : 2'b01;
            end
            if (rready && rvalid) begin
                req_resp  <= rresp;
                req_rdata <= rdata;
                req_done  <= grant_idx ? 2'b10 : 2'b01;
            end
        end
    end

endmodule
